// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional feature macro: SUB_OVERFLOW_EN (adds the signed-overflow output).
package serial_sub_pkg;

  // Default operand and result width.
  localparam int SUB_WIDTH = 4;

  // Control states: waiting, shifting bits through the cell, result valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - b_in, with borrow out.
// Purely combinational; the serial datapath reuses it for every bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  // Difference bit and borrow: borrow when x < y + b_in for this bit.
  always_comb begin
    d     = x ^ y ^ b_in;
    b_out = (~x & y) | (~(x ^ y) & b_in);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - b_in, LSB first, one bit per clock.
// Optional feature macro: SUB_OVERFLOW_EN (adds the ovf port and its flops).
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). An accepted
// start captures A, B and b_in; busy is high for WIDTH cycles, then done
// pulses for one cycle with D/b_out valid. A start seen while busy is
// dropped, not queued. D/b_out hold until the next result is written.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             b_out,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output state_e           dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Holds the WIDTH-1 bits already produced; the last bit goes straight to D.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             b_out_q, b_out_d;
`ifdef SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic cell_d;
  logic cell_bo;

  full_subtractor u_cell (
    .x     (a_sh_q[0]),
    .y     (b_sh_q[0]),
    .b_in  (borrow_q),
    .d     (cell_d),
    .b_out (cell_bo)
  );

  // Next-state and datapath: capture on accepted start, shift while in SHIFT.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    d_d      = d_q;
    b_out_d  = b_out_q;
`ifdef SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          borrow_d = b_in;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef SUB_OVERFLOW_EN
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = cell_bo;
        res_d    = (WIDTH-1)'({cell_d, res_q} >> 1);
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          d_d     = {cell_d, res_q};
          b_out_d = cell_bo;
          state_d = DONE;
`ifdef SUB_OVERFLOW_EN
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      d_q      <= '0;
      b_out_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      d_q      <= d_d;
      b_out_q  <= b_out_d;
`ifdef SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign D         = d_q;
  assign b_out     = b_out_q;
  assign dbg_state = state_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4).
// Build with SUB_OVERFLOW_EN defined to also check the ovf output.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = SUB_WIDTH;
`ifdef SUB_OVERFLOW_EN
  localparam int EW = W + 2;   // {ovf, b_out, D}
`else
  localparam int EW = W + 1;   // {b_out, D}
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
  state_e       dbg_state;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (a),
    .B         (b),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .D         (d),
    .b_out     (b_out),
`ifdef SUB_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            done_cyc[$];
  logic          done_prev = 1'b0;

  function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mbi);
    logic [W:0] full;
    logic [EW-1:0] r;
    full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
    r = '0;
    r[W:0] = full;   // borrow out is the sign bit of the widened difference
`ifdef SUB_OVERFLOW_EN
    r[W+1] = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
`endif
    return r;
  endfunction

  // Compare each done pulse against the oldest expected result.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && done) begin
      done_cyc.push_back(cyc);
      if (done_prev) check_eq("done_pulse_width", 32'd2, 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("d", 32'(d), 32'(e[W-1:0]));
        check_eq("b_out", 32'(b_out), 32'(e[W]));
`ifdef SUB_OVERFLOW_EN
        check_eq("ovf", 32'(ovf), 32'(e[W+1]));
`endif
      end
    end
    done_prev <= rst_n && done;
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi);
    @(negedge clk);
    a = ta; b = tb; b_in = tbi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_q.push_back(model(ta, tb, tbi));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    logic [W-1:0] prev_d;
    logic saw_done;
    int n;
    logic [W-1:0] ra, rb;
    logic rbi;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_d", 32'(d), 32'd0);
    check_eq("rst_b_out", 32'(b_out), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef SUB_OVERFLOW_EN
    check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // 9 - 3: busy for exactly W cycles, D untouched until done.
    run_op(4'd9, 4'd3, 1'b0);
    busy_cnt = 0; saw_done = 1'b0; prev_d = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin saw_done = 1'b1; break; end
      if (busy) begin
        busy_cnt++;
        check_eq("d_hold_busy", 32'(d), 32'(prev_d));
      end
    end
    check_eq("done_seen", 32'(saw_done), 32'd1);
    check_eq("busy_cycles", busy_cnt, W);
    wait_drain("drain_9_3");

    // Directed corner cases.
    run_op(4'd3, 4'd9, 1'b0);  wait_drain("drain_3_9");
    run_op(4'd0, 4'd0, 1'b1);  wait_drain("drain_0_0_1");
    run_op(4'hF, 4'hF, 1'b0);  wait_drain("drain_f_f");
    run_op(4'd7, 4'd8, 1'b0);  wait_drain("drain_7_8");
    run_op(4'd6, 4'd2, 1'b0);  wait_drain("drain_6_2");

    // Start during busy is ignored.
    run_op(4'd5, 4'd2, 1'b0);
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("busy_while_ignored", 32'(busy), 32'd1);
    wait_drain("drain_ignored");

    // Back-to-back: start held through DONE.
    n = done_cyc.size();
    @(negedge clk);
    a = 4'd10; b = 4'd4; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 exp_q.push_back(model(4'd10, 4'd4, 1'b0));
    a = 4'd12; b = 4'd5; b_in = 1'b1;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    @(posedge clk);
    #1 exp_q.push_back(model(4'd12, 4'd5, 1'b1));
    start = 1'b0;
    wait_drain("drain_b2b");
    check_eq("b2b_done_count", done_cyc.size() - n, 2);
    if (done_cyc.size() - n == 2)
      check_eq("b2b_spacing", done_cyc[n+1] - done_cyc[n], W + 1);

    // Reset in the middle of an operation.
    run_op(4'd7, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_d", 32'(d), 32'd0);
    check_eq("midrst_state", 32'(dbg_state), 32'(IDLE));
    // Release reset with start already presented: accepted on the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    a = 4'd8; b = 4'd1; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_q.push_back(model(4'd8, 4'd1, 1'b0));
    check_eq("post_rst_accept", 32'(busy), 32'd1);
    wait_drain("drain_post_rst");

    // Random operations.
    for (int i = 0; i < 20; i++) begin
      ra  = W'($urandom_range(0, (1 << W) - 1));
      rb  = W'($urandom_range(0, (1 << W) - 1));
      rbi = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbi);
      wait_drain("drain_rand");
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
